dmem_arbiter: RTL and testbench

Two-master arbiter that shares the single-port data memory between the core load/store path (master 0) and a secondary requester such as a DMA or debug port (master 1). It grants at most one access per cycle. The write is applied at the clock edge of the grant cycle. Read data is registered and returned to the granted master one cycle later. It sits directly in front of the data memory and drives its WE/A/WD inputs while consuming its combinational RD output.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arb_fsm.sv | 84 ++++++++
 rtl/dmem_arbiter.sv | 83 ++++++++
 tb/tb_dmem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter and the memory it fronts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_arb_pkg;

  // Owner of the previous cycle's grant; IDLE means nobody was granted.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Burst counter width; holds MAX_BURST values up to 15.
  localparam int CNT_W = 4;

  // Defaults shared with the data memory instance.
  localparam int DEF_AW = 10;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/dmem_arb_fsm.sv
// Two-master grant FSM: sticky owner with a burst cap, m0 wins from IDLE.
// Latency: grants are combinational in the request cycle; state moves at the edge.
// Backpressure: a master is held off by simply not being granted; at most MAX_BURST cycles.
module dmem_arb_fsm
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_BURST);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_burst_left;

  assign w_burst_left = (r_cnt < LP_MAX);

  // Owner/burst-count register; reset restarts arbitration from IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Grant decision and next owner/count.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = IDLE;
    w_cnt_nxt   = '0;

    unique case ({i_req1, i_req0})
      2'b01:   w_gnt0 = 1'b1;
      2'b10:   w_gnt1 = 1'b1;
      2'b11: begin
        unique case (r_state)
          OWN0: begin
            w_gnt0 = w_burst_left;
            w_gnt1 = !w_burst_left;
          end
          OWN1: begin
            w_gnt1 = w_burst_left;
            w_gnt0 = !w_burst_left;
          end
          default: w_gnt0 = 1'b1;
        endcase
      end
      default: ;
    endcase

    // Grants are suppressed while reset is held so nothing reaches the memory.
    w_gnt0 = w_gnt0 & rst;
    w_gnt1 = w_gnt1 & rst;

    if (w_gnt0) begin
      w_state_nxt = OWN0;
      w_cnt_nxt   = (r_state == OWN0) ? (w_burst_left ? r_cnt + 1'b1 : LP_MAX)
                                      : CNT_W'(1);
    end else if (w_gnt1) begin
      w_state_nxt = OWN1;
      w_cnt_nxt   = (r_state == OWN1) ? (w_burst_left ? r_cnt + 1'b1 : LP_MAX)
                                      : CNT_W'(1);
    end
  end

  assign o_gnt0 = w_gnt0;
  assign o_gnt1 = w_gnt1;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core (m0) and a secondary master (m1).
// Latency: grant and write in the request cycle; read data/rvalid one cycle after the grant.
// Backpressure: ungranted masters hold req; the burst cap bounds the wait to MAX_BURST+1 cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic          w_m0_gnt;
  logic          w_m1_gnt;
  logic          w_m0_rd;
  logic          w_m1_rd;
  logic          r_m0_rvalid;
  logic          r_m1_rvalid;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;

  dmem_arb_fsm #(
    .MAX_BURST (MAX_BURST)
  ) u_fsm (
    .clk    (clk),
    .rst    (rst),
    .i_req0 (m0_req),
    .i_req1 (m1_req),
    .o_gnt0 (w_m0_gnt),
    .o_gnt1 (w_m1_gnt)
  );

  // m0 drives the memory bus by default so the address is stable when idle.
  assign mem_addr  = w_m1_gnt ? m1_addr  : m0_addr;
  assign mem_wdata = w_m1_gnt ? m1_wdata : m0_wdata;
  assign mem_we    = (w_m0_gnt & m0_we) | (w_m1_gnt & m1_we);

  assign w_m0_rd = w_m0_gnt & !m0_we;
  assign w_m1_rd = w_m1_gnt & !m1_we;

  // Capture read data for the granted reader; rvalid is a one-cycle pulse, rdata holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= w_m0_rd;
      r_m1_rvalid <= w_m1_rd;
      if (w_m0_rd) r_m0_rdata <= mem_rdata;
      if (w_m1_rd) r_m1_rdata <= mem_rdata;
    end
  end

  assign m0_gnt    = w_m0_gnt;
  assign m1_gnt    = w_m1_gnt;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance A uses MAX_BURST=4, instance B uses MAX_BURST=2.
// Both see identical master stimulus, each fronts its own memory array.
// Directed scenarios first, then a randomized run against a reference model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;

  logic          a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_we;
  logic [DW-1:0] a_m0_rdata, a_m1_rdata, a_mem_wdata, a_mem_rdata;
  logic [AW-1:0] a_mem_addr;
  logic          b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_mem_we;
  logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0] b_mem_addr;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata)
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(2)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  // Single-port memories: combinational read, write at the clock edge.
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  assign a_mem_rdata = mem_a[a_mem_addr];
  assign b_mem_rdata = mem_b[b_mem_addr];
  always @(posedge clk) if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
  always @(posedge clk) if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;

  // Reference model: who owns the bus, how long its current streak is,
  // what each master should see next cycle, and the expected memory image.
  int            mbv    [2] = '{4, 2};
  int            own    [2];
  int            streak [2];
  logic          exp_rv [2][2];
  logic [DW-1:0] exp_rd [2][2];
  logic [DW-1:0] ref_mem [2][DEPTH];
  logic          last_b_g1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Who should be granted: a lone requester always; under contention the
  // previous owner keeps the bus until it has had its full burst, m0 wins from idle.
  function automatic int pick(input logic q0, input logic q1, input int o, input int s, input int mb);
    if (!q0 && !q1) return -1;
    if (q0 && !q1)  return 0;
    if (q1 && !q0)  return 1;
    if (o < 0)      return 0;
    return (s < mb) ? o : 1 - o;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      own[k] = -1;
      streak[k] = 0;
      for (int m = 0; m < 2; m++) begin
        exp_rv[k][m] = 1'b0;
        exp_rd[k][m] = '0;
      end
    end
  endtask

  task automatic check_inst(input string nm, input int k, input int g,
                            input logic g0, input logic g1, input logic we,
                            input logic [AW-1:0] ad,
                            input logic rv0, input logic rv1,
                            input logic [DW-1:0] rd0, input logic [DW-1:0] rd1);
    logic exp_we;
    exp_we = (g == 0) ? m0_we : (g == 1) ? m1_we : 1'b0;
    chk({nm, "_m0_gnt"}, 64'(g0), 64'(g == 0));
    chk({nm, "_m1_gnt"}, 64'(g1), 64'(g == 1));
    chk({nm, "_mem_we"}, 64'(we), 64'(exp_we));
    if (g >= 0) chk({nm, "_mem_addr"}, 64'(ad), 64'((g == 1) ? m1_addr : m0_addr));
    chk({nm, "_m0_rvalid"}, 64'(rv0), 64'(exp_rv[k][0]));
    chk({nm, "_m1_rvalid"}, 64'(rv1), 64'(exp_rv[k][1]));
    chk({nm, "_m0_rdata"}, 64'(rd0), 64'(exp_rd[k][0]));
    chk({nm, "_m1_rdata"}, 64'(rd1), 64'(exp_rd[k][1]));
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model, optionally
  // drop reset before the edge, then check A's owner/count just after the edge.
  task automatic cyc(input bit rst_before_edge = 1'b0);
    int g [2];
    arb_state_t es;
    @(negedge clk);
    for (int k = 0; k < 2; k++) g[k] = pick(m0_req, m1_req, own[k], streak[k], mbv[k]);
    check_inst("A", 0, g[0], a_m0_gnt, a_m1_gnt, a_mem_we, a_mem_addr,
               a_m0_rvalid, a_m1_rvalid, a_m0_rdata, a_m1_rdata);
    check_inst("B", 1, g[1], b_m0_gnt, b_m1_gnt, b_mem_we, b_mem_addr,
               b_m0_rvalid, b_m1_rvalid, b_m0_rdata, b_m1_rdata);
    last_b_g1 = b_m1_gnt;
    for (int k = 0; k < 2; k++) begin
      exp_rv[k][0] = 1'b0;
      exp_rv[k][1] = 1'b0;
      if (g[k] >= 0) begin
        logic          w;
        logic [AW-1:0] a;
        w = (g[k] == 1) ? m1_we : m0_we;
        a = (g[k] == 1) ? m1_addr : m0_addr;
        if (w) ref_mem[k][a] = (g[k] == 1) ? m1_wdata : m0_wdata;
        else begin
          exp_rv[k][g[k]] = 1'b1;
          exp_rd[k][g[k]] = ref_mem[k][a];
        end
        if (g[k] == own[k]) streak[k] = (streak[k] + 1 > mbv[k]) ? mbv[k] : streak[k] + 1;
        else begin
          own[k] = g[k];
          streak[k] = 1;
        end
      end else begin
        own[k] = -1;
        streak[k] = 0;
      end
    end
    if (rst_before_edge) begin
      rst = 1'b0;
      model_reset();
    end
    @(posedge clk);
    #1;
    es = (own[0] < 0) ? IDLE : (own[0] == 0) ? OWN0 : OWN1;
    chk("A_state", 64'(dut_a.u_fsm.r_state), 64'(es));
    chk("A_cnt", 64'(dut_a.u_fsm.r_cnt), 64'(streak[0]));
  endtask

  // Everything observable must be quiet while reset is held.
  task automatic rst_chk();
    chk("rst_A_gnt", {62'd0, a_m1_gnt, a_m0_gnt}, 64'd0);
    chk("rst_B_gnt", {62'd0, b_m1_gnt, b_m0_gnt}, 64'd0);
    chk("rst_mem_we", {62'd0, b_mem_we, a_mem_we}, 64'd0);
    chk("rst_rvalid", {60'd0, b_m1_rvalid, b_m0_rvalid, a_m1_rvalid, a_m0_rvalid}, 64'd0);
    chk("rst_A_rdata", {a_m1_rdata, a_m0_rdata}, 64'd0);
    chk("rst_B_rdata", {b_m1_rdata, b_m0_rdata}, 64'd0);
  endtask

  task automatic idle_in();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  logic seq_g1 [8] = '{0, 0, 1, 1, 0, 0, 1, 1};

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = '0; mem_b[i] = '0;
      ref_mem[0][i] = '0; ref_mem[1][i] = '0;
    end
    model_reset();
    // Reset with live write requests: nothing may be granted or written.
    rst = 1'b0;
    idle_in();
    m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1;
    @(posedge clk); #1;
    @(negedge clk);
    rst_chk();
    idle_in();
    rst = 1'b1;
    @(posedge clk); #1;

    // Single write then read by m0.
    m0_req = 1; m0_we = 1; m0_addr = 10'd5; m0_wdata = 32'h0000_00AB;
    cyc();
    m0_we = 0;
    cyc();
    idle_in();
    cyc();
    chk("wr_rd_value", 64'(a_m0_rdata), 64'h0000_00AB);

    // Sustained contention from IDLE; B (burst 2) must alternate in pairs.
    m0_req = 1; m0_addr = 10'd5; m1_req = 1; m1_addr = 10'd5;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("contend_seq_B", 64'(last_b_g1), 64'(seq_g1[i]));
    end
    idle_in();
    cyc();

    // Lone requester: m1 fills addrs 1..4, then reads them back-to-back.
    m1_req = 1; m1_we = 1;
    for (int i = 1; i <= 4; i++) begin
      m1_addr = AW'(i); m1_wdata = 32'hC0DE_0000 + 32'(i);
      cyc();
    end
    m1_we = 0;
    for (int i = 1; i <= 4; i++) begin
      m1_addr = AW'(i);
      cyc();
    end
    idle_in();
    cyc();

    // Cross-master read-after-write.
    m1_req = 1; m1_we = 1; m1_addr = 10'd7; m1_wdata = 32'h0000_1234;
    cyc();
    idle_in();
    m0_req = 1; m0_addr = 10'd7;
    cyc();
    idle_in();
    cyc();
    chk("raw_value", 64'(b_m0_rdata), 64'h0000_1234);

    // Reset between a granted read and its data return.
    m0_req = 1; m0_addr = 10'd7;
    cyc(1'b1);
    rst_chk();
    rst = 1'b1;
    m1_req = 1; m1_addr = 10'd5;
    cyc();
    chk("post_rst_m0_first", 64'(last_b_g1), 64'd0);
    idle_in();
    cyc();

    // Burst boundary on A: m0 owns with cnt 3, drops req while m1 asks.
    m0_req = 1; m0_addr = 10'd2;
    repeat (3) cyc();
    chk("burst_cnt3", 64'(dut_a.u_fsm.r_cnt), 64'd3);
    m0_req = 0; m1_req = 1; m1_addr = 10'd3;
    cyc();
    chk("burst_cnt_after_drop", 64'(dut_a.u_fsm.r_cnt), 64'd1);
    idle_in();
    cyc();

    // Randomized traffic on a small address window to provoke RAW hits.
    for (int i = 0; i < 400; i++) begin
      m0_req   = ($urandom_range(0, 3) != 0);
      m1_req   = ($urandom_range(0, 3) != 0);
      m0_we    = $urandom_range(0, 1) == 1;
      m1_we    = $urandom_range(0, 1) == 1;
      m0_addr  = AW'($urandom_range(0, 15));
      m1_addr  = AW'($urandom_range(0, 15));
      m0_wdata = $urandom;
      m1_wdata = $urandom;
      cyc();
    end
    idle_in();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
